pwm_rgb_duty_sched: RTL
=======================

# pwm_rgb_duty_sched

Scheduler and PWM engine for the RGB LED controller. It shares one unsigned multiplier, 8-bit × 15-bit → 22-bit and purely combinational, across the red, green and blue channels. The three products turn 8-bit brightness levels into duty counts against a programmable period. The block then drives three glitch-free PWM outputs from a common period counter. New settings take effect only at a period boundary.

## Interface
Parameters:
- PERIOD_W, 14: effective period/duty width. The multiplier B port is 15 bits and its MSB is driven 0.
- LEVEL_W, 8: brightness level width. Equals the multiplier A port width.

Ports:
- ap_clk  in  1  single clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  new configuration offered.
- cfg_ready  out  1  high only in IDLE; a transfer occurs when cfg_valid && cfg_ready.
- cfg_period  in  14  period in ap_clk cycles. 0 disables PWM.
- cfg_r, cfg_g, cfg_b  in  8 each  brightness levels.
- mul_a  out  8  multiplier operand A (level).
- mul_b  out  15  multiplier operand B; equals {1'b0, period}.
- mul_p  in  22  multiplier product, valid in the same cycle.
- pwm_r, pwm_g, pwm_b  out  1 each  PWM outputs (registered).
- sync  out  1  one-cycle pulse on every period wrap.
- busy  out  1  high when state ≠ IDLE.

## Operation
- FSM states: IDLE → MUL_R → MUL_G → MUL_B → WAIT_WRAP → IDLE.
  - IDLE: on handshake, latch cfg_period and cfg_r/g/b into staging registers, then go to MUL_R.
  - MUL_x: drive mul_a = staged level and mul_b = {0, staged period}. Capture the pending duty x, then advance to the next state.
  - WAIT_WRAP: hold until the next wrap event. At that event, copy the staged period and pending duties into the active registers, then go to IDLE.
- Duty arithmetic: duty = mul_p[21:8], which is floor(level × period / 256).
  - Level 255 overrides the product: duty = period (fully on).
  - No overflow is possible, since 255 × 16383 < 2^22.
- Outside MUL_x states, mul_a and mul_b are 0.
- Counter cnt, PERIOD_W bits, runs against the active period:
  - If the active period is 0: cnt holds at 0 and no sync pulses occur. A wrap event is asserted every cycle, so a pending configuration applies immediately.
  - Otherwise: cnt increments each cycle. When cnt == period−1, cnt goes to 0, sync pulses, and a wrap event occurs.
- PWM outputs are registered: pwm_x <= (active_period ≠ 0) && (cnt < active_duty_x).
  - Each output is high for exactly duty_x cycles per period, starting one cycle after cnt = 0.
- Simultaneous events:
  - A wrap in the cycle WAIT_WRAP is entered is honoured, so the load occurs on that edge.
  - Active registers change only on a wrap event, so no output can glitch mid-period.
- A cfg_valid arriving while busy is ignored; cfg_ready is low.

## Timing
- Reset (asynchronous, ap_rst_n = 0) clears:
  - state = IDLE, cnt = 0, active period and duties = 0, staging registers = 0;
  - pwm_r/g/b = 0, sync = 0, busy = 0, mul_a = 0, mul_b = 0;
  - cfg_ready = 1 once reset is released.
- Reset mid-sequence aborts the sequence: pending values are discarded and outputs are 0 on the next cycle.
- From handshake edge N: MUL_R in cycle N+1, MUL_G in N+2, MUL_B in N+3, WAIT_WRAP from N+4.
- Apply latency: active registers load on the first wrap at or after N+4. cfg_ready returns high the cycle after that load.
- If the active period is 0, the load happens at edge N+4 and cfg_ready is high at N+5.
- sync is asserted in the cycle where cnt == period−1 and is registered with the wrap.

## Test plan
- Reset with cfg_period = 100, r = 128, g = 255, b = 0 (period initially 0, load at N+4):
  - mul_a sequence is 128, 255, 0 with mul_b = 100 in N+1..N+3;
  - afterwards pwm_r is high 50 of every 100 cycles, pwm_g is constantly 1, pwm_b is constantly 0;
  - sync pulses every 100 cycles.
- Mid-period update: start at period 100, r = 128. Issue a new cfg (r = 64) at cnt = 30.
  - The current period completes with 50 high cycles; the next period has 25.
  - cfg_ready stays low until the wrap.
- Maximum values: period = 16383, r = 254 → duty 16255, and high-cycle count = 16255. Period = 1 with any level < 255 → output constantly 0.
- Busy rejection: hold cfg_valid high through the whole sequence with changing data.
  - Only the first handshake is accepted.
  - A second acceptance occurs one cycle after the apply.
- Disable: apply period = 0 → all pwm outputs go to 0 and stay 0, sync stays silent, and cnt stays 0.
- Asynchronous reset asserted during MUL_G:
  - outputs clear immediately;
  - after release the block is IDLE with cfg_ready = 1, and active duties remain 0.

Source files
------------

// File: rtl/pwm_rgb_duty_sched.sv
// RGB PWM engine. One shared multiplier converts the three brightness levels into duty counts.
// New settings are moved into the active registers only on a period wrap.
//
// state     | meaning
// ----------+----------------------------------------------------
// S_IDLE    | ready for a new configuration
// S_MUL_R   | multiplier computes the red duty
// S_MUL_G   | multiplier computes the green duty
// S_MUL_B   | multiplier computes the blue duty
// S_WAIT    | duties pending, waiting for the period wrap to apply them
module pwm_rgb_duty_sched #(
  parameter int PERIOD_W = 14,
  parameter int LEVEL_W  = 8
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [PERIOD_W-1:0]          cfg_period,
  input  logic [LEVEL_W-1:0]           cfg_r,
  input  logic [LEVEL_W-1:0]           cfg_g,
  input  logic [LEVEL_W-1:0]           cfg_b,
  output logic [LEVEL_W-1:0]           mul_a,
  output logic [PERIOD_W:0]            mul_b,
  input  logic [PERIOD_W+LEVEL_W-1:0]  mul_p,
  output logic                         pwm_r,
  output logic                         pwm_g,
  output logic                         pwm_b,
  output logic                         sync,
  output logic                         busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL_R = 3'd1;
  localparam logic [2:0] S_MUL_G = 3'd2;
  localparam logic [2:0] S_MUL_B = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  localparam logic [PERIOD_W-1:0] ONE     = PERIOD_W'(1);
  localparam logic [LEVEL_W-1:0]  LVL_MAX = '1;

  logic [2:0]          state_q, state_d;
  logic [PERIOD_W-1:0] stg_period_q, stg_period_d;
  logic [LEVEL_W-1:0]  stg_r_q, stg_r_d, stg_g_q, stg_g_d, stg_b_q, stg_b_d;
  logic [PERIOD_W-1:0] pend_r_q, pend_r_d, pend_g_q, pend_g_d, pend_b_q, pend_b_d;
  logic [PERIOD_W-1:0] act_period_q, act_period_d;
  logic [PERIOD_W-1:0] act_r_q, act_r_d, act_g_q, act_g_d, act_b_q, act_b_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                pwm_r_q, pwm_r_d, pwm_g_q, pwm_g_d, pwm_b_q, pwm_b_d;
  logic                sync_q, sync_d;

  logic [LEVEL_W-1:0]  lvl;
  logic                mul_on;
  logic [PERIOD_W-1:0] duty;
  logic                at_end;
  logic                wrap;
  logic                unused_mul_lsb;

  always_comb begin
    lvl = '0;
    case (state_q)
      S_MUL_R: lvl = stg_r_q;
      S_MUL_G: lvl = stg_g_q;
      S_MUL_B: lvl = stg_b_q;
      default: lvl = '0;
    endcase
  end

  assign mul_on = (state_q == S_MUL_R) || (state_q == S_MUL_G) || (state_q == S_MUL_B);
  assign mul_a  = lvl;
  assign mul_b  = mul_on ? {1'b0, stg_period_q} : '0;
  // full-scale level bypasses the product so the output can be on for the whole period
  assign duty   = (lvl == LVL_MAX) ? stg_period_q : mul_p[PERIOD_W+LEVEL_W-1:LEVEL_W];
  assign unused_mul_lsb = ^mul_p[LEVEL_W-1:0];

  assign at_end = (act_period_q != '0) && (cnt_q == act_period_q - ONE);
  assign wrap   = (act_period_q == '0) || at_end;

  always_comb begin
    state_d      = state_q;
    stg_period_d = stg_period_q;
    stg_r_d      = stg_r_q;
    stg_g_d      = stg_g_q;
    stg_b_d      = stg_b_q;
    pend_r_d     = pend_r_q;
    pend_g_d     = pend_g_q;
    pend_b_d     = pend_b_q;
    act_period_d = act_period_q;
    act_r_d      = act_r_q;
    act_g_d      = act_g_q;
    act_b_d      = act_b_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          stg_period_d = cfg_period;
          stg_r_d      = cfg_r;
          stg_g_d      = cfg_g;
          stg_b_d      = cfg_b;
          state_d      = S_MUL_R;
        end
      end
      S_MUL_R: begin
        pend_r_d = duty;
        state_d  = S_MUL_G;
      end
      S_MUL_G: begin
        pend_g_d = duty;
        state_d  = S_MUL_B;
      end
      S_MUL_B: begin
        pend_b_d = duty;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (wrap) begin
          act_period_d = stg_period_q;
          act_r_d      = pend_r_q;
          act_g_d      = pend_g_q;
          act_b_d      = pend_b_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (act_period_q == '0 || at_end) cnt_d = '0;
    else                              cnt_d = cnt_q + ONE;

    sync_d  = at_end;
    pwm_r_d = (act_period_q != '0) && (cnt_q < act_r_q);
    pwm_g_d = (act_period_q != '0) && (cnt_q < act_g_q);
    pwm_b_d = (act_period_q != '0) && (cnt_q < act_b_q);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= S_IDLE;
      stg_period_q <= '0;
      stg_r_q      <= '0;
      stg_g_q      <= '0;
      stg_b_q      <= '0;
      pend_r_q     <= '0;
      pend_g_q     <= '0;
      pend_b_q     <= '0;
      act_period_q <= '0;
      act_r_q      <= '0;
      act_g_q      <= '0;
      act_b_q      <= '0;
      cnt_q        <= '0;
      pwm_r_q      <= 1'b0;
      pwm_g_q      <= 1'b0;
      pwm_b_q      <= 1'b0;
      sync_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stg_period_q <= stg_period_d;
      stg_r_q      <= stg_r_d;
      stg_g_q      <= stg_g_d;
      stg_b_q      <= stg_b_d;
      pend_r_q     <= pend_r_d;
      pend_g_q     <= pend_g_d;
      pend_b_q     <= pend_b_d;
      act_period_q <= act_period_d;
      act_r_q      <= act_r_d;
      act_g_q      <= act_g_d;
      act_b_q      <= act_b_d;
      cnt_q        <= cnt_d;
      pwm_r_q      <= pwm_r_d;
      pwm_g_q      <= pwm_g_d;
      pwm_b_q      <= pwm_b_d;
      sync_q       <= sync_d;
    end
  end

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign pwm_r     = pwm_r_q;
  assign pwm_g     = pwm_g_q;
  assign pwm_b     = pwm_b_q;
  assign sync      = sync_q;

endmodule
